// File: rtl/ex_ctrl_pkg.sv
// Shared encodings for the execute-stage controller and the fetch-stage
// branch predictor: opcodes, branch condition codes, flag bit positions, FSM states.
package ex_ctrl_pkg;

  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_PADDSB = 4'b0001;
  localparam logic [3:0] OP_SUB    = 4'b0010;
  localparam logic [3:0] OP_AND    = 4'b0011;
  localparam logic [3:0] OP_NOR    = 4'b0100;
  localparam logic [3:0] OP_SLL    = 4'b0101;
  localparam logic [3:0] OP_SRL    = 4'b0110;
  localparam logic [3:0] OP_SRA    = 4'b0111;
  localparam logic [3:0] OP_LW     = 4'b1000;
  localparam logic [3:0] OP_SW     = 4'b1001;
  localparam logic [3:0] OP_LHB    = 4'b1010;
  localparam logic [3:0] OP_LLB    = 4'b1011;
  localparam logic [3:0] OP_B      = 4'b1100;
  localparam logic [3:0] OP_CALL   = 4'b1101;
  localparam logic [3:0] OP_RET    = 4'b1110;
  localparam logic [3:0] OP_HLT    = 4'b1111;

  localparam logic [2:0] CC_NE  = 3'b000;
  localparam logic [2:0] CC_EQ  = 3'b001;
  localparam logic [2:0] CC_GT  = 3'b010;
  localparam logic [2:0] CC_LT  = 3'b011;
  localparam logic [2:0] CC_GTE = 3'b100;
  localparam logic [2:0] CC_LTE = 3'b101;
  localparam logic [2:0] CC_OVF = 3'b110;
  localparam logic [2:0] CC_ALW = 3'b111;

  localparam int FLG_N = 2;
  localparam int FLG_V = 1;
  localparam int FLG_Z = 0;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

endpackage

// File: rtl/ex_ctrl_if.sv
// ID/EX-side bus of the execute controller. The master drives the decoded
// instruction and pipeline control; the slave (ex_ctrl) returns ALU control,
// flags, branch redirect and status.
interface ex_ctrl_if #(parameter int CNT_W = 16);
  logic             valid_in;
  logic [3:0]       opcode_in;
  logic [2:0]       cond_in;
  logic             stall;
  logic             flush;
  logic [2:0]       alu_flags;
  logic [3:0]       alu_op;
  logic             ex_valid;
  logic [2:0]       flags_q;
  logic             branch_taken;
  logic             halted;
  logic [CNT_W-1:0] retired;

  modport master (
    output valid_in, opcode_in, cond_in, stall, flush, alu_flags,
    input  alu_op, ex_valid, flags_q, branch_taken, halted, retired
  );

  modport slave (
    input  valid_in, opcode_in, cond_in, stall, flush, alu_flags,
    output alu_op, ex_valid, flags_q, branch_taken, halted, retired
  );
endinterface

// File: rtl/ex_ctrl_br_cond.sv
// Branch condition evaluator on a {N,V,Z} flag vector; purely combinational
// so the fetch-stage predictor can share it.
module br_cond
  import ex_ctrl_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [2:0] flags,
  output logic       take
);

  // Decode the condition field against the current flags
  always_comb begin
    take = 1'b0;
    case (cond)
      CC_NE:   take = ~flags[FLG_Z];
      CC_EQ:   take =  flags[FLG_Z];
      CC_GT:   take = ~flags[FLG_Z] & ~flags[FLG_N];
      CC_LT:   take =  flags[FLG_N];
      CC_GTE:  take =  flags[FLG_Z] | ~flags[FLG_N];
      CC_LTE:  take =  flags[FLG_N] |  flags[FLG_Z];
      CC_OVF:  take =  flags[FLG_V];
      default: take = 1'b1;
    endcase
  end

endmodule

// File: rtl/ex_ctrl.sv
// Execute-stage controller: ID/EX control register, ALUop drive, {N,V,Z}
// flag register, branch resolution, HLT sequencing and retire counter.
module ex_ctrl
  import ex_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic         clk,
  input logic         rst,
  ex_ctrl_if.slave    bus
);

  state_t           state_q, state_d;
  logic             ex_vld_q;
  logic [3:0]       ex_op_q;
  logic [2:0]       ex_cc_q;
  logic [2:0]       flag_q, flag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire;
  logic             cond_take;
  logic             halted;
  logic [3:0]       alu_op;
  logic             branch_taken;
  logic             ex_load;

  // A live EX instruction retires unless it is being held by a bare stall
  assign retire  = ex_vld_q & (~bus.stall | bus.flush) & (state_q == ST_RUN);
  // Opcode/cond only matter while valid, so they load whenever the slot advances
  assign ex_load = (state_d == ST_RUN) & ~bus.flush & ~bus.stall;

  br_cond u_br_cond (
    .cond  (ex_cc_q),
    .flags (flag_q),
    .take  (cond_take)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  // FSM next state: a retiring HLT parks the controller until reset
  always_comb begin
    state_d = state_q;
    if (state_q == ST_RUN && retire && ex_op_q == OP_HLT) state_d = ST_HALT;
  end

  // FSM outputs and EX-driven combinational controls
  always_comb begin
    halted       = (state_q == ST_HALT);
    alu_op       = 4'b0000;
    branch_taken = 1'b0;
    if (ex_vld_q) begin
      if (ex_op_q < OP_B) alu_op = ex_op_q;
      branch_taken = ((ex_op_q == OP_B) & cond_take) |
                     (ex_op_q == OP_CALL) | (ex_op_q == OP_RET);
    end
  end

  // EX valid bit: bubble on halt or flush, hold on stall, else take ID
  always_ff @(posedge clk) begin
    if (rst)                                  ex_vld_q <= 1'b0;
    else if (state_d == ST_HALT || bus.flush) ex_vld_q <= 1'b0;
    else if (!bus.stall)                      ex_vld_q <= bus.valid_in;
  end

  // EX opcode/condition payload (no reset; qualified by ex_vld_q)
  always_ff @(posedge clk) begin
    if (ex_load) begin
      ex_op_q <= bus.opcode_in;
      ex_cc_q <= bus.cond_in;
    end
  end

  // Flag merge by opcode class, only on the retire edge
  always_comb begin
    flag_d = flag_q;
    if (retire) begin
      case (ex_op_q)
        OP_ADD, OP_SUB: flag_d = bus.alu_flags;
        OP_AND, OP_NOR, OP_SLL, OP_SRL, OP_SRA:
          flag_d[FLG_Z] = bus.alu_flags[FLG_Z];
        default: flag_d = flag_q;
      endcase
    end
  end

  // Retired-instruction count, wrapping naturally at 2^CNT_W
  always_comb begin
    cnt_d = retire ? cnt_q + 1'b1 : cnt_q;
  end

  // Architectural flag and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      flag_q <= 3'b000;
      cnt_q  <= '0;
    end else begin
      flag_q <= flag_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.alu_op       = alu_op;
  assign bus.ex_valid     = ex_vld_q;
  assign bus.flags_q      = flag_q;
  assign bus.branch_taken = branch_taken;
  assign bus.halted       = halted;
  assign bus.retired      = cnt_q;

endmodule

// File: doc/ex_ctrl.md
# ex_ctrl

Execute-stage controller for the 16-bit ALU datapath. It holds the ID/EX control register and drives the ALU's 4-bit `ALUop` from the decoded opcode. It owns the architectural flag register {N,V,Z}, merging ALU flags per opcode class, and evaluates branch conditions. It also handles stall/flush/halt sequencing and counts retired instructions.

## Interface
Parameters:
- `CNT_W`, 16: width of retired-instruction counter.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `valid_in`  in  1  ID stage presents a valid instruction.
- `opcode_in`  in  4  instruction opcode [15:12].
- `cond_in`  in  3  branch condition field [11:9].
- `stall`  in  1  hold EX contents; the EX instruction does not retire.
- `flush`  in  1  discard the instruction entering EX.
- `alu_flags`  in  3  {neg, ov, zr} from the ALU for the current EX op.
- `alu_op`  out  4  ALUop to the ALU, taken from the EX register.
- `ex_valid`  out  1  EX holds a live instruction.
- `flags_q`  out  3  flag register {N,V,Z}.
- `branch_taken`  out  1  redirect the PC (combinational).
- `halted`  out  1  HALT state.
- `retired`  out  CNT_W  retired-instruction count.

## Operation
- Opcode map: 0000 ADD, 0001 PADDSB, 0010 SUB, 0011 AND, 0100 NOR, 0101 SLL, 0110 SRL, 0111 SRA, 1000 LW, 1001 SW, 1010 LHB, 1011 LLB, 1100 B, 1101 CALL, 1110 RET, 1111 HLT.
- `alu_op` = EX opcode for 0000–1011; 0000 (ADD) for 1100–1111; 0000 when EX is a bubble.
- Flag merge on retire:
  - ADD/SUB: N,V,Z ← alu_flags.
  - AND/NOR/SLL/SRL/SRA: Z ← zr only; N and V keep their values.
  - All other opcodes leave flags unchanged.
- Branch conditions evaluated on `flags_q`:
  - 000 NE: Z=0
  - 001 EQ: Z=1
  - 010 GT: Z=0 and N=0
  - 011 LT: N=1
  - 100 GTE: Z=1 or N=0
  - 101 LTE: N=1 or Z=1
  - 110 OVF: V=1
  - 111 always
- `branch_taken` = ex_valid & ((B & cond true) | CALL | RET).
- FSM with two states:
  - RUN → HALT when HLT retires.
  - HALT → RUN only on `rst`.
  - In HALT, EX holds a bubble, inputs are ignored, and `halted`=1.
- Retire condition: retire = ex_valid & (!stall | flush) & state==RUN. On retire, `retired` increments and wraps modulo 2^CNT_W.

## Timing
- Reset values: ex_valid=0, alu_op=0000, flags_q=000, branch_taken=0, halted=0, retired=0, state RUN.
- EX register load priority at each edge: rst > HALT (bubble) > flush (bubble) > stall (hold) > load {valid_in, opcode_in, cond_in}.
- `stall` and `flush` together: flush wins. The EX instruction retires (flags and counter update) and a bubble is loaded.
- Flag write happens at the retire edge, so a B in the next EX cycle sees the new flags with zero bubbles.
- Stalled cycles never write flags, so repeated ALU evaluation has no effect.
- `branch_taken` is valid in the same cycle as EX; upstream logic must assert `flush` in that same cycle.
- Reset mid-operation discards EX contents; flags and counter clear at that edge.

## Structure
- A shared package holds:
  - opcode localparams (4-bit),
  - condition-code localparams (3-bit),
  - flag bit indices (N=2, V=1, Z=0),
  - FSM state encoding.
- One sub-module, `br_cond`, is natural: purely combinational, inputs cond[2:0] and flags[2:0], output take. It is reused by the fetch-stage predictor.

## Test plan
- Reset: assert rst with valid_in=1 → all outputs at reset values next cycle.
- Flag merge:
  - ADD retires with alu_flags=110 → flags_q=110.
  - Then AND with alu_flags=001 → flags_q=111.
  - Then PADDSB with alu_flags=000 → flags_q unchanged.
- Back-to-back: SUB with alu_flags=001 followed by B cond=001 → branch_taken=1 in the B's EX cycle. Same sequence with cond=000 → branch_taken=0.
- Stall: ADD held 3 cycles by stall, alu_flags changing each cycle → flags_q takes only the value from the release cycle; retired increments by 1.
- Stall+flush: both asserted with SUB in EX → SUB retires, ex_valid=0 next cycle, and the incoming opcode is not loaded.
- Halt and wrap:
  - HLT retires → halted=1 and ex_valid stays 0 despite valid_in=1; rst returns to RUN.
  - With retired preloaded to 16'hFFFF, one retire → 16'h0000.
